// File: rtl/dram_responder.sv
// dram_responder: cycle-based DRAM device model with CL-deep read pipeline and sticky command error flag.
// Define DRAM_TIMING_CHK_EN to enforce TRCD/TRP; otherwise activate/precharge complete immediately.
module dram_responder #(
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 6,
  parameter int CL       = 5,
  parameter int TRCD     = 3,
  parameter int TRP      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DRAM_CSn,
  input  logic [3:0]  DRAM_WEn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_valid,
  output logic        cmd_err
);
  localparam int AW = ROW_BITS + COL_BITS;
  typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} state_t;
  state_t              r_state;
  logic [ROW_BITS-1:0] r_row;
  logic [31:0]         r_mem [2**AW];
  logic [31:0]         r_pipe_d [CL];
  logic [CL-1:0]       r_pipe_v;
  logic [31:0]         r_q;
  logic                r_valid;
  logic                r_err;
  logic w_act, w_pre, w_rd, w_wr, w_idle, w_open, w_pre_err;
  logic w_act_ok, w_pre_ok, w_rd_ok, w_wr_ok, w_err, w_unused;
  logic [AW-1:0] w_addr;
  assign w_unused = &{1'b0, DRAM_A};
  assign w_act = !DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF;
  assign w_pre = !DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0;
  assign w_rd  = !DRAM_CSn && DRAM_RASn && !DRAM_CASn && DRAM_WEn == 4'hF;
  assign w_wr  = !DRAM_CSn && DRAM_RASn && !DRAM_CASn && DRAM_WEn != 4'hF;
`ifdef DRAM_TIMING_CHK_EN
  localparam int CW = $clog2((TRCD > TRP ? TRCD : TRP) + 1);
  logic [CW-1:0] r_cnt;
  // A zero count means the timing window has elapsed on this edge, so the next state is already in force.
  assign w_idle    = r_state == IDLE || (r_state == PRECHARGING && r_cnt == '0);
  assign w_open    = r_state == ACTIVE || (r_state == ACTIVATING && r_cnt == '0);
  assign w_pre_err = r_state == ACTIVATING && r_cnt != '0;
`else
  assign w_idle    = r_state == IDLE;
  assign w_open    = r_state == ACTIVE;
  assign w_pre_err = 1'b0;
`endif
  assign w_act_ok = w_act && w_idle;
  assign w_pre_ok = w_pre && w_open;
  assign w_rd_ok  = w_rd && w_open;
  assign w_wr_ok  = w_wr && w_open;
  assign w_err    = (w_act && !w_idle) || ((w_rd || w_wr) && !w_open) || (w_pre && w_pre_err);
  assign w_addr   = {r_row, DRAM_A[COL_BITS-1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
`ifdef DRAM_TIMING_CHK_EN
      r_cnt   <= '0;
`endif
    end else begin
      if (w_act_ok) r_row <= DRAM_A[ROW_BITS-1:0];
`ifdef DRAM_TIMING_CHK_EN
      if (w_act_ok) begin
        r_state <= ACTIVATING;
        r_cnt   <= CW'(TRCD - 1);
      end else if (w_pre_ok) begin
        r_state <= PRECHARGING;
        r_cnt   <= CW'(TRP - 1);
      end else if (r_state == ACTIVATING && r_cnt == '0) r_state <= ACTIVE;
      else if (r_state == PRECHARGING && r_cnt == '0) r_state <= IDLE;
      else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
`else
      if (w_act_ok) r_state <= ACTIVE;
      else if (w_pre_ok) r_state <= IDLE;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok)
      for (int i = 0; i < 4; i++)
        if (!DRAM_WEn[i]) r_mem[w_addr][8*i +: 8] <= DRAM_D[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    r_pipe_d[0] <= r_mem[w_addr];
    for (int i = 1; i < CL; i++) r_pipe_d[i] <= r_pipe_d[i-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_v <= '0;
      r_q      <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_pipe_v[0] <= w_rd_ok;
      for (int i = 1; i < CL; i++) r_pipe_v[i] <= r_pipe_v[i-1];
      r_valid <= r_pipe_v[CL-1];
      if (r_pipe_v[CL-1]) r_q <= r_pipe_d[CL-1];
      r_err <= r_err || w_err;
    end
  end
  assign DRAM_Q     = r_q;
  assign DRAM_valid = r_valid;
  assign cmd_err    = r_err;
endmodule
